mpu_clk_sequencer: RTL and testbench

Run-control sequencer for the 6502 phi2 clock, driven from the 50 MHz board clock.
- Generates mpu_clk and supports free run, halt, single-step, N-step and an opcode-fetch breakpoint.
- The clock always stops with mpu_clk held high.
- Sits between the debounced front-panel/debug-UART control signals and the MPU clock pin.
- Provides phase strobes and a cycle counter for bus-monitor logic.

---
 rtl/mpu_clk_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_mpu_clk_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_clk_sequencer.sv
// mpu_clk_sequencer
// -----------------
// Run-control sequencer for the 6502 phi2 clock, derived from the 50 MHz
// board clock. It supports free run, halt, single-step, N-step and an
// opcode-fetch breakpoint. The MPU clock is only ever stopped while high, and
// a halt never shortens a high phase.
//
// Ports
//   clk          50 MHz system clock
//   rst          asynchronous, active-low reset
//   run          1 = free run requested (debounced level)
//   step         single-step pulse, one clk wide (acted on only when halted)
//   step_n_go    N-step start pulse, one clk wide (acted on only when halted)
//   step_n       N-step cycle count, sampled on step_n_go
//   bp_en        breakpoint enable
//   bp_addr      breakpoint address
//   mpu_addr     6502 address bus
//   mpu_sync     6502 SYNC (opcode fetch)
//   cyc_clr      synchronous clear of cycle_count (wins over increment)
//   mpu_clk      phi2 to the 6502
//   phi_fall     one-clk strobe in the cycle mpu_clk becomes 0
//   phi_rise     one-clk strobe in the cycle mpu_clk becomes 1
//   halted       1 while the sequencer is halted
//   bp_hit       sticky breakpoint flag, cleared when the sequencer leaves halt
//   steps_left   remaining N-step cycles
//   cycle_count  number of mpu_clk falling edges, wraps at 2^32
//
// HALF_PERIOD is the number of clk cycles per mpu_clk phase (legal 2..255).

module mpu_clk_sequencer #(
  parameter int HALF_PERIOD = 25,
  parameter int ADDR_W      = 16,
  parameter int STEP_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step,
  input  logic              step_n_go,
  input  logic [STEP_W-1:0] step_n,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] mpu_addr,
  input  logic              mpu_sync,
  input  logic              cyc_clr,
  output logic              mpu_clk,
  output logic              phi_fall,
  output logic              phi_rise,
  output logic              halted,
  output logic              bp_hit,
  output logic [STEP_W-1:0] steps_left,
  output logic [31:0]       cycle_count
);

  typedef enum logic [1:0] {
    ST_HALTED,
    ST_RUN,
    ST_STEP
  } state_e;

  localparam logic [7:0] TERM_CNT = 8'(HALF_PERIOD - 1);

  state_e            state_q;
  logic [7:0]        cnt_q;
  logic              mpu_clk_q;
  logic              phi_fall_q;
  logic              phi_rise_q;
  logic              halted_q;
  logic              bp_hit_q;
  logic              mask_q;        // suppresses the breakpoint for the first MPU cycle after a halt
  logic [STEP_W-1:0] steps_left_q;
  logic [31:0]       cycle_count_q;

  logic              bp_match;
  logic              terminal;
  logic              start;
  logic              stop;
  logic [STEP_W-1:0] steps_left_d;

  assign bp_match     = bp_en & mpu_sync & (mpu_addr == bp_addr) & ~mask_q;
  assign terminal     = (cnt_q == TERM_CNT);
  assign steps_left_d = steps_left_q - STEP_W'(1);

  // Any request that takes the sequencer out of HALTED.
  assign start = run | (step_n_go & (|step_n)) | step;

  // Halt decision, only meaningful at the end of a high phase. run is not
  // consulted while stepping; it is picked up again once halted.
  assign stop = (state_q == ST_STEP) ? ((steps_left_d == '0) | bp_match)
                                     : (~run | bp_match);

  // NOTE: every register below is assigned with <= so all updates in this
  // block see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_HALTED;
      cnt_q         <= '0;
      mpu_clk_q     <= 1'b1;
      phi_fall_q    <= 1'b0;
      phi_rise_q    <= 1'b0;
      halted_q      <= 1'b1;
      bp_hit_q      <= 1'b0;
      mask_q        <= 1'b0;
      steps_left_q  <= '0;
      cycle_count_q <= '0;
    end else begin
      phi_fall_q <= 1'b0;
      phi_rise_q <= 1'b0;

      case (state_q)
        ST_HALTED: begin
          mpu_clk_q <= 1'b1;
          cnt_q     <= '0;
          if (run) begin
            state_q <= ST_RUN;
          end else if (step_n_go && (step_n != '0)) begin
            state_q      <= ST_STEP;
            steps_left_q <= step_n;
          end else if (step) begin
            state_q      <= ST_STEP;
            steps_left_q <= STEP_W'(1);
          end
          // Leaving halt starts a low phase immediately.
          if (start) begin
            mpu_clk_q     <= 1'b0;
            phi_fall_q    <= 1'b1;
            halted_q      <= 1'b0;
            bp_hit_q      <= 1'b0;
            mask_q        <= 1'b1;
            cycle_count_q <= cycle_count_q + 32'd1;
          end
        end

        ST_RUN, ST_STEP: begin
          if (!terminal) begin
            cnt_q <= cnt_q + 8'd1;
          end else begin
            cnt_q <= '0;
            if (!mpu_clk_q) begin
              mpu_clk_q  <= 1'b1;
              phi_rise_q <= 1'b1;
            end else begin
              // End of a high phase: the only place a halt is taken.
              mask_q <= 1'b0;
              if (state_q == ST_STEP) steps_left_q <= steps_left_d;
              if (stop) begin
                state_q  <= ST_HALTED;
                halted_q <= 1'b1;
                bp_hit_q <= bp_match;
              end else begin
                mpu_clk_q     <= 1'b0;
                phi_fall_q    <= 1'b1;
                cycle_count_q <= cycle_count_q + 32'd1;
              end
            end
          end
        end

        default: begin
          state_q   <= ST_HALTED;
          halted_q  <= 1'b1;
          mpu_clk_q <= 1'b1;
          cnt_q     <= '0;
        end
      endcase

      // NOTE: the last non-blocking assignment to a register in a block wins,
      // so placing the clear here gives it priority over any increment above.
      if (cyc_clr) cycle_count_q <= '0;
    end
  end

  assign mpu_clk     = mpu_clk_q;
  assign phi_fall    = phi_fall_q;
  assign phi_rise    = phi_rise_q;
  assign halted      = halted_q;
  assign bp_hit      = bp_hit_q;
  assign steps_left  = steps_left_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_mpu_clk_sequencer.sv
// Testbench for mpu_clk_sequencer: free run timing, run drop, single/N-step
// table with a scoreboard, breakpoint halt and resume, asynchronous reset.

module tb_mpu_clk_sequencer;

  localparam int HP = 25;
  localparam int AW = 16;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          step_n_go = 1'b0;
  logic [SW-1:0] step_n = '0;
  logic          bp_en = 1'b0;
  logic [AW-1:0] bp_addr = '0;
  logic [AW-1:0] mpu_addr = '0;
  logic          mpu_sync = 1'b0;
  logic          cyc_clr = 1'b0;
  logic          mpu_clk;
  logic          phi_fall;
  logic          phi_rise;
  logic          halted;
  logic          bp_hit;
  logic [SW-1:0] steps_left;
  logic [31:0]   cycle_count;

  mpu_clk_sequencer #(
    .HALF_PERIOD(HP),
    .ADDR_W     (AW),
    .STEP_W     (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step       (step),
    .step_n_go  (step_n_go),
    .step_n     (step_n),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .mpu_addr   (mpu_addr),
    .mpu_sync   (mpu_sync),
    .cyc_clr    (cyc_clr),
    .mpu_clk    (mpu_clk),
    .phi_fall   (phi_fall),
    .phi_rise   (phi_rise),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .steps_left (steps_left),
    .cycle_count(cycle_count)
  );

  always #10 clk = ~clk;

  // Step-table vectors and scoreboard entries.
  typedef struct {
    logic        use_n;
    logic        also_step;
    logic [15:0] n;
    int          exp_falls;
    int          exp_sl0;
  } vec_t;

  typedef struct {
    int          falls;
    logic [31:0] cc;
    int          sl0;
  } sb_t;

  vec_t vecs[5];
  sb_t  sb_q[$];
  sb_t  exp_e;
  int   sl_q[$];
  int   fall_t[$];
  int   rise_t[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          falls = 0;
  int          rises = 0;
  int          last_fall = 0;
  int          last_rise = 0;
  int          last_halt = 0;
  logic        prev_halted = 1'b1;
  logic [31:0] m_cc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Advance one clk and sample outputs 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (phi_fall) begin
      falls++;
      last_fall = cyc;
      fall_t.push_back(cyc);
      sl_q.push_back(int'(steps_left));
    end
    if (phi_rise) begin
      rises++;
      last_rise = cyc;
      rise_t.push_back(cyc);
    end
    if (halted && !prev_halted) last_halt = cyc;
    prev_halted = halted;
  endtask

  task automatic clear_counts();
    falls = 0;
    rises = 0;
    fall_t.delete();
    rise_t.delete();
    sl_q.delete();
  endtask

  task automatic wait_halted(input string name, input int budget);
    for (int g = 0; g < budget && !halted; g++) tick();
    check(name, 32'(halted), 32'd1);
  endtask

  // Bus model for the breakpoint test: cycle 7 is the opcode fetch at E000,
  // cycle 4 puts E000 on the bus without SYNC.
  task automatic drive_bus(input int k);
    if (k == 7) begin
      mpu_sync = 1'b1;
      mpu_addr = 16'hE000;
    end else if (k == 4) begin
      mpu_sync = 1'b0;
      mpu_addr = 16'hE000;
    end else begin
      mpu_sync = 1'b1;
      mpu_addr = 16'h1000 + 16'(k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'd0, 1, 1};  // single step
    vecs[1] = '{1'b1, 1'b0, 16'd3, 3, 3};  // N-step 3
    vecs[2] = '{1'b1, 1'b0, 16'd0, 0, 0};  // N-step 0 is a no-op
    vecs[3] = '{1'b1, 1'b1, 16'd2, 2, 2};  // N-step wins over step
    vecs[4] = '{1'b1, 1'b1, 16'd0, 1, 1};  // N-step 0 with step falls to single step

    // ---------------- reset state, then free run ----------------
    run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst mpu_clk", 32'(mpu_clk), 32'd1);
    check("rst halted", 32'(halted), 32'd1);
    check("rst phi_fall", 32'(phi_fall), 32'd0);
    check("rst phi_rise", 32'(phi_rise), 32'd0);
    check("rst bp_hit", 32'(bp_hit), 32'd0);
    check("rst steps_left", 32'(steps_left), 32'd0);
    check("rst cycle_count", cycle_count, 32'd0);
    rst = 1'b1;
    clear_counts();
    tick();
    check("run first phi_fall", 32'(phi_fall), 32'd1);
    check("run first mpu_clk", 32'(mpu_clk), 32'd0);
    for (int g = 0; g < 1000 && falls < 10; g++) tick();
    check("run falls", 32'(falls), 32'd10);
    check("run cycle_count 10", cycle_count, 32'd10);
    if (falls == 10 && rises >= 1) begin
      check("run period", 32'(fall_t[1] - fall_t[0]), 32'd50);
      check("run low width", 32'(rise_t[0] - fall_t[0]), 32'd25);
      check("run high width", 32'(fall_t[1] - rise_t[0]), 32'd25);
      check("run period late", 32'(fall_t[9] - fall_t[8]), 32'd50);
    end

    // cyc_clr coinciding with a falling edge must win over the increment.
    repeat (49) tick();
    cyc_clr = 1'b1;
    tick();
    cyc_clr = 1'b0;
    check("clr fall strobe", 32'(phi_fall), 32'd1);
    check("clr priority", cycle_count, 32'd0);
    m_cc = 0;

    // N-step requests while running are ignored.
    step_n    = 16'd7;
    step_n_go = 1'b1;
    tick();
    step_n_go = 1'b0;
    check("run ignores step_n_go", 32'(steps_left), 32'd0);
    check("run not halted", 32'(halted), 32'd0);

    // ---------------- drop run 10 clks into a low phase ----------------
    repeat (8) tick();
    run = 1'b0;
    clear_counts();
    wait_halted("drop halted", 200);
    check("drop rises", 32'(rises), 32'd1);
    check("drop no fall", 32'(falls), 32'd0);
    check("drop high width", 32'(last_halt - last_rise), 32'd25);
    check("drop mpu_clk", 32'(mpu_clk), 32'd1);
    repeat (100) tick();
    check("drop quiet falls", 32'(falls), 32'd0);
    check("drop still halted", 32'(halted), 32'd1);
    check("drop cycle_count", cycle_count, m_cc);

    // ---------------- step table with scoreboard ----------------
    for (int i = 0; i < 5; i++) begin
      m_cc      = m_cc + 32'(vecs[i].exp_falls);
      exp_e.falls = vecs[i].exp_falls;
      exp_e.cc    = m_cc;
      exp_e.sl0   = vecs[i].exp_sl0;
      sb_q.push_back(exp_e);
      clear_counts();
      step_n    = vecs[i].n;
      step_n_go = vecs[i].use_n;
      step      = vecs[i].also_step;
      tick();
      step_n_go = 1'b0;
      step      = 1'b0;
      repeat (2 * HP * 8) tick();
      exp_e = sb_q.pop_front();
      check($sformatf("vec%0d falls", i), 32'(falls), 32'(exp_e.falls));
      check($sformatf("vec%0d rises", i), 32'(rises), 32'(exp_e.falls));
      check($sformatf("vec%0d cycle_count", i), cycle_count, exp_e.cc);
      check($sformatf("vec%0d halted", i), 32'(halted), 32'd1);
      check($sformatf("vec%0d mpu_clk", i), 32'(mpu_clk), 32'd1);
      check($sformatf("vec%0d steps_left end", i), 32'(steps_left), 32'd0);
      for (int k = 0; k < sl_q.size(); k++)
        check($sformatf("vec%0d steps_left@fall%0d", i, k), 32'(sl_q[k]), 32'(exp_e.sl0 - k));
      if (exp_e.falls > 0) begin
        check($sformatf("vec%0d low width", i), 32'(last_rise - last_fall), 32'd25);
        check($sformatf("vec%0d rise to halt", i), 32'(last_halt - last_rise), 32'd25);
      end
    end

    // ---------------- breakpoint ----------------
    cyc_clr = 1'b1;
    tick();
    cyc_clr = 1'b0;
    check("bp clr count", cycle_count, 32'd0);
    m_cc    = 0;
    bp_en   = 1'b1;
    bp_addr = 16'hE000;
    clear_counts();
    drive_bus(0);
    run = 1'b1;
    for (int g = 0; g < 1000; g++) begin
      tick();
      drive_bus(falls);
      if (halted) break;
    end
    run = 1'b0;
    m_cc = 7;
    check("bp halted", 32'(halted), 32'd1);
    check("bp falls", 32'(falls), 32'd7);
    check("bp cycle_count", cycle_count, m_cc);
    check("bp_hit set", 32'(bp_hit), 32'd1);
    check("bp mpu_clk", 32'(mpu_clk), 32'd1);
    check("bp full high", 32'(last_halt - last_rise), 32'd25);
    repeat (5) tick();
    check("bp_hit sticky", 32'(bp_hit), 32'd1);

    // Single step off the breakpoint with the match still on the bus.
    clear_counts();
    step = 1'b1;
    tick();
    step = 1'b0;
    check("bp step fall", 32'(phi_fall), 32'd1);
    check("bp_hit cleared", 32'(bp_hit), 32'd0);
    repeat (200) tick();
    m_cc = m_cc + 1;
    check("bp step falls", 32'(falls), 32'd1);
    check("bp step no rehit", 32'(bp_hit), 32'd0);
    check("bp step halted", 32'(halted), 32'd1);
    check("bp step cycle_count", cycle_count, m_cc);

    // Resume with run: match held through the first cycle must not halt.
    clear_counts();
    run = 1'b1;
    for (int g = 0; g < 600; g++) begin
      tick();
      if (falls >= 2) mpu_addr = 16'h2000;
      if (falls == 4) break;
    end
    check("resume falls", 32'(falls), 32'd4);
    check("resume running", 32'(halted), 32'd0);
    check("resume bp_hit", 32'(bp_hit), 32'd0);
    bp_en = 1'b0;

    // ---------------- asynchronous reset 10 clks into a low phase ----------------
    repeat (10) tick();
    check("pre-rst low", 32'(mpu_clk), 32'd0);
    rst = 1'b0;
    #1;
    check("async rst mpu_clk", 32'(mpu_clk), 32'd1);
    check("async rst halted", 32'(halted), 32'd1);
    check("async rst cycle_count", cycle_count, 32'd0);
    check("async rst steps_left", 32'(steps_left), 32'd0);
    check("async rst bp_hit", 32'(bp_hit), 32'd0);
    clear_counts();
    repeat (3) tick();
    check("in rst no falls", 32'(falls), 32'd0);
    check("in rst mpu_clk", 32'(mpu_clk), 32'd1);
    rst = 1'b1;
    tick();
    check("post rst fall", 32'(phi_fall), 32'd1);
    check("post rst count", cycle_count, 32'd1);
    for (int g = 0; g < 1000 && falls < 3; g++) tick();
    run = 1'b0;
    wait_halted("post rst halted", 200);
    check("post rst cycle_count", cycle_count, 32'd3);
    check("post rst mpu_clk", 32'(mpu_clk), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
